mod_up_chain_sched: RTL and testbench

// Round-robin scheduler that shares one hierarchical forwarding chain (main -> level2 -> level3
// and back up) between NUM_REQ requesters. It grants one requester at a time, drives its

---
 rtl/mod_up_chain_sched.sv | 166 ++++++++++++++++
 tb/tb_mod_up_chain_sched.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mod_up_chain_sched.sv
// Round-robin scheduler sharing one forwarding chain between NUM_REQ requesters.
// It grants one requester, issues its operand to the chain, and waits for the
// response under a timeout. It then returns the result with a one-cycle done pulse.
module mod_up_chain_sched #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 15
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        gnt,
    output logic                      chain_valid,
    output logic [DATA_W-1:0]         chain_data,
    input  logic                      chain_ready,
    input  logic                      resp_valid,
    input  logic [DATA_W-1:0]         resp_data,
    output logic [NUM_REQ-1:0]        done,
    output logic [DATA_W-1:0]         done_data,
    output logic                      timeout_err,
    output logic                      busy
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = 8;
    // The WAIT cycle with this count is the last one allowed to see a response.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [PTR_W-1:0] PTR_RESET = PTR_W'(NUM_REQ - 1);
    localparam logic [NUM_REQ-1:0] ONE_REQ = {{(NUM_REQ-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [PTR_W-1:0]   sel_q, sel_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic               chain_valid_q, chain_valid_d;
    logic [DATA_W-1:0]  chain_data_q, chain_data_d;
    logic [NUM_REQ-1:0] done_q, done_d;
    logic [DATA_W-1:0]  done_data_q, done_data_d;
    logic               timeout_err_q, timeout_err_d;
    logic               busy_q, busy_d;

    logic               arb_found;
    logic [PTR_W-1:0]   arb_sel;
    int                 arb_idx;
    logic [PTR_W-1:0]   arb_idx_w;

    // Round-robin search: first asserted request after the last winner, wrapping.
    always_comb begin
        arb_found = 1'b0;
        arb_sel   = '0;
        arb_idx   = 0;
        arb_idx_w = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            arb_idx   = (int'(ptr_q) + i) % NUM_REQ;
            arb_idx_w = PTR_W'(arb_idx);
            if (!arb_found && req[arb_idx_w]) begin
                arb_found = 1'b1;
                arb_sel   = arb_idx_w;
            end
        end
    end

    // Next-state and registered-output computation for the IDLE/ISSUE/WAIT/DONE flow.
    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        sel_d         = sel_q;
        cnt_d         = cnt_q;
        gnt_d         = gnt_q;
        chain_valid_d = chain_valid_q;
        chain_data_d  = chain_data_q;
        done_d        = '0;
        done_data_d   = done_data_q;
        timeout_err_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (arb_found) begin
                    state_d       = ST_ISSUE;
                    sel_d         = arb_sel;
                    gnt_d         = ONE_REQ << arb_sel;
                    chain_valid_d = 1'b1;
                    chain_data_d  = req_data[arb_sel*DATA_W +: DATA_W];
                end
            end
            ST_ISSUE: begin
                if (chain_ready) begin
                    state_d       = ST_WAIT;
                    chain_valid_d = 1'b0;
                    cnt_d         = '0;
                end
            end
            ST_WAIT: begin
                if (resp_valid) begin
                    state_d     = ST_DONE;
                    done_d      = gnt_q;
                    done_data_d = resp_data;
                end else if (cnt_q == CNT_LAST) begin
                    state_d       = ST_DONE;
                    done_d        = gnt_q;
                    done_data_d   = '0;
                    timeout_err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                ptr_d   = sel_q;
                gnt_d   = '0;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers, cleared asynchronously with the pointer primed for requester 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            ptr_q         <= PTR_RESET;
            sel_q         <= '0;
            cnt_q         <= '0;
            gnt_q         <= '0;
            chain_valid_q <= 1'b0;
            chain_data_q  <= '0;
            done_q        <= '0;
            done_data_q   <= '0;
            timeout_err_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            sel_q         <= sel_d;
            cnt_q         <= cnt_d;
            gnt_q         <= gnt_d;
            chain_valid_q <= chain_valid_d;
            chain_data_q  <= chain_data_d;
            done_q        <= done_d;
            done_data_q   <= done_data_d;
            timeout_err_q <= timeout_err_d;
            busy_q        <= busy_d;
        end
    end

    assign gnt         = gnt_q;
    assign chain_valid = chain_valid_q;
    assign chain_data  = chain_data_q;
    assign done        = done_q;
    assign done_data   = done_data_q;
    assign timeout_err = timeout_err_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_mod_up_chain_sched.sv
// Bench for mod_up_chain_sched. The bench plays both the requesters and the chain.
// A transaction-level model predicts each grant, operand, result and timeout.
module tb_mod_up_chain_sched;

    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 8;
    localparam int TIMEOUT = 15;

    logic                      clk = 1'b0;
    logic                      rst_n;
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        gnt;
    logic                      chain_valid;
    logic [DATA_W-1:0]         chain_data;
    logic                      chain_ready;
    logic                      resp_valid;
    logic [DATA_W-1:0]         resp_data;
    logic [NUM_REQ-1:0]        done;
    logic [DATA_W-1:0]         done_data;
    logic                      timeout_err;
    logic                      busy;

    int errCount   = 0;
    int checkCount = 0;

    // Model state: who is requesting, each requester's operand, and the last winner.
    logic [NUM_REQ-1:0] pending;
    logic [DATA_W-1:0]  opData [NUM_REQ];
    int                 lastWinner;

    mod_up_chain_sched #(
        .NUM_REQ(NUM_REQ),
        .DATA_W (DATA_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .req_data   (req_data),
        .gnt        (gnt),
        .chain_valid(chain_valid),
        .chain_data (chain_data),
        .chain_ready(chain_ready),
        .resp_valid (resp_valid),
        .resp_data  (resp_data),
        .done       (done),
        .done_data  (done_data),
        .timeout_err(timeout_err),
        .busy       (busy)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports any mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
        end
    endtask

    // Round-robin rule: the first pending requester after the last winner, wrapping.
    function automatic int pickWinner();
        for (int k = 1; k <= NUM_REQ; k++) begin
            int c = (lastWinner + k) % NUM_REQ;
            if (pending[c]) return c;
        end
        return -1;
    endfunction

    function automatic logic [31:0] oneHot(input int i);
        return 32'(1) << i;
    endfunction

    // Checks that every output is at its reset value.
    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_gnt"},   32'(gnt),         32'd0);
        checkOutput({tag, "_cv"},    32'(chain_valid), 32'd0);
        checkOutput({tag, "_cd"},    32'(chain_data),  32'd0);
        checkOutput({tag, "_done"},  32'(done),        32'd0);
        checkOutput({tag, "_dd"},    32'(done_data),   32'd0);
        checkOutput({tag, "_terr"},  32'(timeout_err), 32'd0);
        checkOutput({tag, "_busy"},  32'(busy),        32'd0);
    endtask

    // One full arbitration round starting from an idle cycle at a falling edge.
    // The task raises any newly requesting inputs and holds off chain_ready for
    // readyDelay cycles. The response arrives on WAIT cycle respLat; a value of
    // TIMEOUT or more means no response. opVal/resVal of -1 select random data.
    task automatic applyStimulus(input logic [NUM_REQ-1:0] newReq, input int readyDelay,
                                 input int respLat, input int opVal, input int resVal,
                                 input bit spurious, input bit dropEarly);
        int               w;
        logic [DATA_W-1:0] expOp;
        logic [DATA_W-1:0] expRes;
        bit               timedOut;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (newReq[i] && !pending[i]) begin
                pending[i] = 1'b1;
                opData[i]  = (opVal >= 0) ? DATA_W'(opVal) : DATA_W'($urandom);
                req_data[i*DATA_W +: DATA_W] = opData[i];
            end
        end
        req         = pending;
        chain_ready = 1'b0;
        resp_valid  = 1'b0;
        w = pickWinner();
        @(negedge clk);
        if (w < 0) begin
            checkOutput("idle_gnt",  32'(gnt),  32'd0);
            checkOutput("idle_busy", 32'(busy), 32'd0);
            return;
        end
        expOp = opData[w];
        checkOutput("grant_gnt",  32'(gnt),         oneHot(w));
        checkOutput("grant_cv",   32'(chain_valid), 32'd1);
        checkOutput("grant_cd",   32'(chain_data),  32'(expOp));
        checkOutput("grant_busy", 32'(busy),        32'd1);
        checkOutput("grant_done", 32'(done),        32'd0);
        req_data[w*DATA_W +: DATA_W] = ~expOp;
        if (dropEarly) begin
            pending[w] = 1'b0;
            req        = pending;
        end
        for (int k = 0; k < readyDelay; k++) begin
            chain_ready = 1'b0;
            resp_valid  = spurious;
            resp_data   = DATA_W'($urandom);
            @(negedge clk);
            checkOutput("issue_cv",   32'(chain_valid), 32'd1);
            checkOutput("issue_cd",   32'(chain_data),  32'(expOp));
            checkOutput("issue_gnt",  32'(gnt),         oneHot(w));
            checkOutput("issue_done", 32'(done),        32'd0);
        end
        chain_ready = 1'b1;
        resp_valid  = spurious;
        resp_data   = DATA_W'($urandom);
        @(negedge clk);
        chain_ready = 1'b0;
        resp_valid  = 1'b0;
        checkOutput("wait_cv",   32'(chain_valid), 32'd0);
        checkOutput("wait_busy", 32'(busy),        32'd1);
        expRes   = (resVal >= 0) ? DATA_W'(resVal) : DATA_W'($urandom);
        timedOut = 1'b0;
        for (int k = 0; k <= TIMEOUT; k++) begin
            resp_valid = (k == respLat);
            resp_data  = (k == respLat) ? expRes : DATA_W'($urandom);
            @(negedge clk);
            resp_valid = 1'b0;
            if (k == respLat) break;
            if (k == TIMEOUT - 1) begin
                timedOut = 1'b1;
                break;
            end
            checkOutput("wait_done", 32'(done), 32'd0);
            checkOutput("wait_gnt",  32'(gnt),  oneHot(w));
        end
        checkOutput("done_done", 32'(done),        oneHot(w));
        checkOutput("done_data", 32'(done_data),   timedOut ? 32'd0 : 32'(expRes));
        checkOutput("done_terr", 32'(timeout_err), 32'(timedOut));
        checkOutput("done_gnt",  32'(gnt),         oneHot(w));
        checkOutput("done_busy", 32'(busy),        32'd1);
        pending[w] = 1'b0;
        req        = pending;
        lastWinner = w;
        resp_valid = spurious;
        resp_data  = DATA_W'($urandom);
        @(negedge clk);
        resp_valid = 1'b0;
        checkOutput("post_done", 32'(done),        32'd0);
        checkOutput("post_gnt",  32'(gnt),         32'd0);
        checkOutput("post_terr", 32'(timeout_err), 32'd0);
        checkOutput("post_busy", 32'(busy),        32'd0);
        checkOutput("post_cv",   32'(chain_valid), 32'd0);
    endtask

    // Directed scenarios first, then a randomized run against the model.
    initial begin
        rst_n       = 1'b0;
        req         = '0;
        req_data    = '0;
        chain_ready = 1'b0;
        resp_valid  = 1'b0;
        resp_data   = '0;
        pending     = '0;
        lastWinner  = NUM_REQ - 1;
        for (int i = 0; i < NUM_REQ; i++) opData[i] = '0;

        #12;
        checkResetOutputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Single requester, zero-wait response.
        applyStimulus(4'b0001, 0, 0, 8'h5A, 8'hA5, 1'b0, 1'b0);
        // Silent chain: timeout abort.
        applyStimulus(4'b0100, 0, TIMEOUT, -1, -1, 1'b0, 1'b0);
        // Chain stalls the handshake for five cycles.
        applyStimulus(4'b0010, 5, 2, -1, -1, 1'b0, 1'b0);
        // Response on the last allowed WAIT cycle wins over the timeout.
        applyStimulus(4'b1000, 0, TIMEOUT - 1, -1, 8'h3C, 1'b0, 1'b0);

        // Reset while waiting for a response.
        req_data[1*DATA_W +: DATA_W] = 8'h77;
        req = 4'b0010;
        @(negedge clk);
        chain_ready = 1'b1;
        @(negedge clk);
        chain_ready = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 checkResetOutputs("midrst");
        @(negedge clk);
        rst_n      = 1'b1;
        req        = '0;
        pending    = '0;
        lastWinner = NUM_REQ - 1;

        // All requesters held: the grant order must be 0,1,2,3,0.
        for (int t = 0; t < 5; t++) begin
            applyStimulus(4'b1111, 0, 0, -1, -1, 1'b0, 1'b0);
            checkOutput("rr_order", 32'(lastWinner), 32'(t % NUM_REQ));
        end

        // Randomized traffic mixing stalls, latencies, timeouts and spurious responses.
        for (int t = 0; t < 80; t++) begin
            int r;
            int lat;
            r = $urandom_range(0, 9);
            if (r < 6)       lat = $urandom_range(0, 4);
            else if (r == 6) lat = TIMEOUT - 1;
            else if (r == 7) lat = TIMEOUT;
            else             lat = $urandom_range(0, TIMEOUT - 1);
            applyStimulus(NUM_REQ'($urandom_range(0, 15)), $urandom_range(0, 3), lat, -1, -1,
                          1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
